// File: rtl/path_mailbox_pkg.sv
// Shared address map, error-bit indices and store decode for the path-result mailbox.
package path_mailbox_pkg;

    localparam logic [31:0] OFS_START = 32'd0;
    localparam logic [31:0] OFS_END   = 32'd4;
    localparam logic [31:0] OFS_NODE  = 32'd8;
    localparam logic [31:0] OFS_DONE  = 32'd12;

    localparam int ERR_BAD_DONE = 0;
    localparam int ERR_OVERFLOW = 1;
    localparam int ERR_RANGE    = 2;
    localparam int ERR_LATE     = 3;
    localparam int ERR_W        = 4;

    typedef enum logic [1:0] {
        ST_NONE,
        ST_NODE,
        ST_DONE
    } store_kind_e;

    // Only the node and done words matter; start/end words are snooped but ignored.
    function automatic store_kind_e decode_store(input logic        mem_write,
                                                 input logic [31:0] adr,
                                                 input logic [31:0] base);
        store_kind_e kind;
        kind = ST_NONE;
        if (mem_write && adr == base + OFS_NODE)      kind = ST_NODE;
        else if (mem_write && adr == base + OFS_DONE) kind = ST_DONE;
        return kind;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; push while full succeeds only alongside a pop.
module sync_fifo #(
    parameter int  DEPTH = 16,
    parameter int  WIDTH = 5,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; entries are only visible through count/empty.
    always_ff @(posedge clk) begin
        if (reset && !clr && do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/path_result_mailbox.sv
// Snoops CPU stores to the path-planner block, queues node points for the host, tracks done/error flags.
module path_result_mailbox
    import path_mailbox_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          DEPTH     = 16,
    parameter int          NODE_W    = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       MemWrite,
    input  logic [31:0]                DataAdr,
    input  logic [31:0]                WriteData,
    input  logic                       clr,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [NODE_W-1:0]          rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       done,
    output logic [ERR_W-1:0]           err
);

    store_kind_e kind;
    logic        node_st;
    logic        done_st;
    logic        pop;
    logic        push;
    logic        full;
    logic        empty;

    assign kind     = decode_store(MemWrite, DataAdr, BASE_ADDR);
    assign node_st  = (kind == ST_NODE);
    assign done_st  = (kind == ST_DONE);
    assign rd_valid = ~empty;
    assign pop      = rd_valid & rd_ready;
    // Once done is seen, further node points are late and never enter the queue.
    assign push     = node_st & ~done;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (NODE_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .wdata (WriteData[NODE_W-1:0]),
        .rdata (rd_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            done <= 1'b0;
            err  <= '0;
        end else begin
            if (node_st) begin
                if (|WriteData[31:NODE_W]) err[ERR_RANGE] <= 1'b1;
                if (done)                  err[ERR_LATE] <= 1'b1;
                else if (full && !pop)     err[ERR_OVERFLOW] <= 1'b1;
            end
            if (done_st) begin
                if (WriteData == 32'd1)       done <= 1'b1;
                else if (WriteData != 32'd0)  err[ERR_BAD_DONE] <= 1'b1;
            end
        end
    end

endmodule

// File: doc/path_result_mailbox.md
PATH_RESULT_MAILBOX -- requirements
Module: path_result_mailbox

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h02000000, base of the path-planner parameter block.
REQ-002 SHALL have parameter DEPTH, default 16, node FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter NODE_W, default 5, stored node-point width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port MemWrite  input  1  CPU store strobe, snooped.
REQ-007 SHALL have port DataAdr  input  32  CPU store address.
REQ-008 SHALL have port WriteData  input  32  CPU store data.
REQ-009 SHALL have port clr  input  1  host synchronous clear pulse.
REQ-010 SHALL have port rd_ready  input  1  host accepts head entry.
REQ-011 SHALL have port rd_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port rd_data  output  NODE_W  FIFO head node point.
REQ-013 SHALL have port count  output  $clog2(DEPTH+1)  current FIFO occupancy.
REQ-014 SHALL have port done  output  1  sticky CPU-done flag.
REQ-015 SHALL have port err  output  4  sticky {late, range, overflow, bad_done}.

Function
REQ-016 Node store = MemWrite & DataAdr==BASE_ADDR+8; SHALL push WriteData[NODE_W-1:0] into FIFO.
REQ-017 Node store with WriteData[31:NODE_W]!=0 SHALL still push truncated value and set err[2] (range).
REQ-018 Node store while count==DEPTH and no pop same cycle SHALL be dropped and set err[1] (overflow).
REQ-019 Done store = MemWrite & DataAdr==BASE_ADDR+12; WriteData==1 SHALL set done next cycle; WriteData==0 SHALL be ignored; any other value SHALL set err[0] and leave done unchanged.
REQ-020 Node store while done==1 SHALL be dropped and set err[3] (late).
REQ-021 Stores to any other address (incl. BASE+0, BASE+4) SHALL be ignored.
REQ-022 Pushed entry SHALL appear on rd_data/rd_valid the cycle after the store edge (1-cycle latency).
REQ-023 Pop SHALL occur on rd_valid & rd_ready; rd_data SHALL be stable while rd_valid & !rd_ready.
REQ-024 Simultaneous push and pop when full SHALL both succeed, count unchanged, no overflow.
REQ-025 Push when empty with rd_ready high SHALL push only (no pop, rd_valid low that cycle).
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; FIFO order SHALL be strict first-in-first-out.
REQ-027 clr SHALL empty FIFO and clear done and err next cycle, overriding any same-cycle store or pop.
REQ-028 err bits and done SHALL be sticky until clr or reset.

Reset
REQ-029 With reset low at a rising edge: count=0, rd_valid=0, done=0, err=0, pointers=0; rd_data is don't-care while rd_valid=0.
REQ-030 Reset SHALL override clr, stores and pops; reset mid-stream SHALL discard all entries.
REQ-031 While reset is low, snooped stores SHALL have no effect.

Structure
REQ-032 Shared package path_mailbox_pkg SHALL hold address offsets OFS_START=0, OFS_END=4, OFS_NODE=8, OFS_DONE=12 and err bit index constants.
REQ-033 FIFO storage/pointers SHALL be one sub-module sync_fifo (parameters DEPTH, WIDTH; push/pop/full/empty/count); decode and flags stay in top.

Verification
REQ-034 Reset, then stores 0x02000008 data 3,7,12 with rd_ready=0 -> count=3; then rd_ready=1 -> rd_data 3,7,12 on consecutive cycles, rd_valid low after.
REQ-035 17 node stores, no pops -> count=16, err=4'b0010, rd_data sequence first 16 values.
REQ-036 FIFO full, rd_ready=1, node store 9 same cycle -> count stays 16, err[1]=0, 9 last out.
REQ-037 Store 0x0200000C data 1, then node store 5 -> done=1, err[3]=1, count unchanged; store 0x0200000C data 2 from clean state -> done=0, err[0]=1.
REQ-038 Node store data 32'h25 -> rd_data=5'h05, err[2]=1; store to 0x02000004 -> no effect.
REQ-039 clr asserted same cycle as node store with 4 entries and done=1 -> next cycle count=0, done=0, err=0.
